// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared constants for the multicycle MIPS-subset controller and
// its datapath. It holds the opcode/funct codes, the FSM state encoding,
// the ULA operation codes, every mux-select encoding and the control-word
// struct. It also holds the datapath constants that the mux inputs
// reference (SP reset value and the exception vector addresses).
package ctrl_pkg;

  // Datapath constants; the controller only selects them.
  localparam int SP_RESET_VAL = 227;
  localparam int EXC_ADDR_OPC = 253;
  localparam int EXC_ADDR_OVF = 254;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;

  typedef enum logic [4:0] {
    S_RESET   = 5'd0,
    S_FETCH   = 5'd1,
    S_DECODE  = 5'd2,
    S_RTYPE   = 5'd3,
    S_ADDI    = 5'd4,
    S_LW      = 5'd5,
    S_SW      = 5'd6,
    S_BRANCH  = 5'd7,
    S_JUMP    = 5'd8,
    S_EXC_OPC = 5'd9,
    S_EXC_OVF = 5'd10
  } state_t;

  localparam logic [2:0] ULA_LOAD = 3'b000;
  localparam logic [2:0] ULA_ADD  = 3'b001;
  localparam logic [2:0] ULA_SUB  = 3'b010;
  localparam logic [2:0] ULA_AND  = 3'b011;
  localparam logic [2:0] ULA_CMP  = 3'b111;

  localparam logic       A_PC = 1'b0;
  localparam logic       A_A  = 1'b1;

  localparam logic [1:0] B_B       = 2'b00;
  localparam logic [1:0] B_FOUR    = 2'b01;
  localparam logic [1:0] B_SEXT    = 2'b10;
  localparam logic [1:0] B_SEXT_SH = 2'b11;

  localparam logic [1:0] WREG_RT = 2'b00;
  localparam logic [1:0] WREG_RD = 2'b01;
  localparam logic [1:0] WREG_29 = 2'b10;
  localparam logic [1:0] WREG_31 = 2'b11;

  localparam logic [2:0] WDATA_ALU = 3'b000;
  localparam logic [2:0] WDATA_MDR = 3'b001;
  localparam logic [2:0] WDATA_SP  = 3'b010;

  localparam logic [2:0] MEM_PC      = 3'b000;
  localparam logic [2:0] MEM_ALU     = 3'b001;
  localparam logic [2:0] MEM_EXC_OPC = 3'b010;
  localparam logic [2:0] MEM_EXC_OVF = 3'b011;

  localparam logic [2:0] PC_ULA  = 3'b000;
  localparam logic [2:0] PC_ALU  = 3'b001;
  localparam logic [2:0] PC_JUMP = 3'b010;
  localparam logic [2:0] PC_MDR  = 3'b011;

  typedef struct packed {
    logic       pc_w;
    logic       mem_w;
    logic       ir_w;
    logic       mdr_w;
    logic       rb_w;
    logic       ab_w;
    logic       alu_w;
    logic       epc_w;
    logic [2:0] ula_c;
    logic       sel_a;
    logic [1:0] sel_b;
    logic [1:0] sel_wreg;
    logic [2:0] sel_wdata;
    logic [2:0] sel_mem;
    logic [2:0] sel_pcsrc;
    logic       rst_out;
  } ctrl_t;

  function automatic logic [2:0] funct_ula(logic [5:0] funct);
    case (funct)
      FN_ADD:  return ULA_ADD;
      FN_SUB:  return ULA_SUB;
      FN_AND:  return ULA_AND;
      default: return ULA_LOAD;
    endcase
  endfunction

  // Execute state chosen at the end of DECODE.
  function automatic state_t dispatch(logic [5:0] opcode, logic [5:0] funct);
    case (opcode)
      OP_RTYPE:       return (funct == FN_ADD || funct == FN_SUB || funct == FN_AND)
                             ? S_RTYPE : S_EXC_OPC;
      OP_ADDI:        return S_ADDI;
      OP_LW:          return S_LW;
      OP_SW:          return S_SW;
      OP_BEQ, OP_BNE: return S_BRANCH;
      OP_J:           return S_JUMP;
      default:        return S_EXC_OPC;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: purely combinational decode of the controller.
// Inputs : state, cnt (cycle within state), opcode, funct, of, eq.
// Outputs: ctl (Moore control word from state/cnt, with eq gating the
//          branch PC write) and nxt (next state).
module ctrl_decode
  import ctrl_pkg::*;
(
  input  state_t      state,
  input  logic [2:0]  cnt,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        of,
  input  logic        eq,
  output ctrl_t       ctl,
  output state_t      nxt
);

  always_comb begin
    nxt = state;
    case (state)
      S_RESET:  nxt = S_FETCH;
      S_FETCH:  if (cnt == 3'd2) nxt = S_DECODE;
      S_DECODE: if (cnt == 3'd1) nxt = dispatch(opcode, funct);
      // Only add/sub reach the overflow trap; and never overflows.
      S_RTYPE:  if (cnt == 3'd0) begin
                  if (of && funct != FN_AND) nxt = S_EXC_OVF;
                end else nxt = S_FETCH;
      S_ADDI:   if (cnt == 3'd0) begin
                  if (of) nxt = S_EXC_OVF;
                end else nxt = S_FETCH;
      S_LW:     if (cnt == 3'd4) nxt = S_FETCH;
      S_SW:     if (cnt == 3'd1) nxt = S_FETCH;
      S_BRANCH, S_JUMP: nxt = S_FETCH;
      S_EXC_OPC, S_EXC_OVF: if (cnt == 3'd4) nxt = S_FETCH;
      default:  nxt = S_RESET;
    endcase
  end

  always_comb begin
    ctl = '0;
    case (state)
      S_RESET: begin
        ctl.rb_w      = 1'b1;
        ctl.sel_wreg  = WREG_29;
        ctl.sel_wdata = WDATA_SP;
      end
      S_FETCH: begin
        // PC+4 stays on the ULA through c2 so the PC write picks it up.
        ctl.sel_mem = MEM_PC;
        ctl.sel_a   = A_PC;
        ctl.sel_b   = B_FOUR;
        ctl.ula_c   = ULA_ADD;
        if (cnt == 3'd2) begin
          ctl.ir_w      = 1'b1;
          ctl.pc_w      = 1'b1;
          ctl.sel_pcsrc = PC_ULA;
        end
      end
      S_DECODE: if (cnt == 3'd0) begin
        ctl.ab_w  = 1'b1;
        ctl.alu_w = 1'b1;
        ctl.sel_a = A_PC;
        ctl.sel_b = B_SEXT_SH;
        ctl.ula_c = ULA_ADD;
      end
      S_RTYPE, S_ADDI: if (cnt == 3'd0) begin
        ctl.sel_a = A_A;
        ctl.sel_b = (state == S_ADDI) ? B_SEXT : B_B;
        ctl.ula_c = (state == S_ADDI) ? ULA_ADD : funct_ula(funct);
        ctl.alu_w = 1'b1;
      end else begin
        ctl.rb_w      = 1'b1;
        ctl.sel_wreg  = (state == S_ADDI) ? WREG_RT : WREG_RD;
        ctl.sel_wdata = WDATA_ALU;
      end
      S_LW, S_SW: case (cnt)
        3'd0: begin
          ctl.sel_a = A_A;
          ctl.sel_b = B_SEXT;
          ctl.ula_c = ULA_ADD;
          ctl.alu_w = 1'b1;
        end
        3'd1, 3'd2: begin
          ctl.sel_mem = MEM_ALU;
          ctl.mem_w   = (state == S_SW);
        end
        3'd3: ctl.mdr_w = 1'b1;
        default: begin
          ctl.rb_w      = 1'b1;
          ctl.sel_wreg  = WREG_RT;
          ctl.sel_wdata = WDATA_MDR;
        end
      endcase
      S_BRANCH: begin
        ctl.sel_a     = A_A;
        ctl.sel_b     = B_B;
        ctl.ula_c     = ULA_CMP;
        ctl.sel_pcsrc = PC_ALU;
        ctl.pc_w      = (opcode == OP_BEQ) ? eq : !eq;
      end
      S_JUMP: begin
        ctl.pc_w      = 1'b1;
        ctl.sel_pcsrc = PC_JUMP;
      end
      S_EXC_OPC, S_EXC_OVF: case (cnt)
        3'd0: begin
          // EPC <= PC-4: PC was already advanced during FETCH.
          ctl.epc_w = 1'b1;
          ctl.sel_a = A_PC;
          ctl.sel_b = B_FOUR;
          ctl.ula_c = ULA_SUB;
        end
        3'd1, 3'd2: ctl.sel_mem = (state == S_EXC_OVF) ? MEM_EXC_OVF : MEM_EXC_OPC;
        3'd3: ctl.mdr_w = 1'b1;
        default: begin
          ctl.pc_w      = 1'b1;
          ctl.sel_pcsrc = PC_MDR;
        end
      endcase
      default: ctl = '0;
    endcase
  end

endmodule

// File: rtl/ctrl_unit_mc.sv
// ctrl_unit_mc: multicycle control FSM for the MIPS-subset datapath.
// Inputs : clk, reset (sync, active-high), opcode/funct from IR, ULA of/eq.
// Outputs: datapath write enables, ula_c, mux selects, rst_out, state_dbg.
// Holds the state/counter registers; decode lives in ctrl_decode.
module ctrl_unit_mc
  import ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       of,
  input  logic       eq,
  output logic       pc_w,
  output logic       mem_w,
  output logic       ir_w,
  output logic       mdr_w,
  output logic       rb_w,
  output logic       ab_w,
  output logic       alu_w,
  output logic       epc_w,
  output logic [2:0] ula_c,
  output logic       m_sel_a,
  output logic [1:0] m_sel_b,
  output logic [1:0] m_sel_wreg,
  output logic [2:0] m_sel_wdata,
  output logic [2:0] m_sel_mem,
  output logic [2:0] m_sel_pcsrc,
  output logic       rst_out,
  output logic [4:0] state_dbg
);

  state_t     state, nxt;
  logic [2:0] cnt;
  ctrl_t      ctl_d, ctl;

  ctrl_decode u_dec (
    .state  (state),
    .cnt    (cnt),
    .opcode (opcode),
    .funct  (funct),
    .of     (of),
    .eq     (eq),
    .ctl    (ctl_d),
    .nxt    (nxt)
  );

  // Counter restarts whenever the state changes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_RESET;
      cnt   <= '0;
    end else begin
      state <= nxt;
      cnt   <= (nxt != state) ? 3'd0 : cnt + 3'd1;
    end
  end

  // Reset masks the decoded word combinationally so an aborted instruction
  // asserts nothing in the cycle reset is seen.
  always_comb begin
    ctl = ctl_d;
    if (reset) begin
      ctl         = '0;
      ctl.rst_out = 1'b1;
    end
  end

  assign pc_w        = ctl.pc_w;
  assign mem_w       = ctl.mem_w;
  assign ir_w        = ctl.ir_w;
  assign mdr_w       = ctl.mdr_w;
  assign rb_w        = ctl.rb_w;
  assign ab_w        = ctl.ab_w;
  assign alu_w       = ctl.alu_w;
  assign epc_w       = ctl.epc_w;
  assign ula_c       = ctl.ula_c;
  assign m_sel_a     = ctl.sel_a;
  assign m_sel_b     = ctl.sel_b;
  assign m_sel_wreg  = ctl.sel_wreg;
  assign m_sel_wdata = ctl.sel_wdata;
  assign m_sel_mem   = ctl.sel_mem;
  assign m_sel_pcsrc = ctl.sel_pcsrc;
  assign rst_out     = ctl.rst_out;
  assign state_dbg   = state;

endmodule
